rs232_tx_fifo: RTL and testbench
================================

# rs232_tx_fifo

Parametrised RS-232 transmitter with an internal byte FIFO and RTS/CTS-style flow control, driving the FT232 RXD line from the 133 MHz OSCH clock domain. Upstream logic pushes words through a valid/ready handshake. The block serialises them LSB-first with configurable data bits, parity and stop bits, using a fractional baud generator. Frame starts are gated by the host's flow-control input.

## Interface
- CLOCK_FREQ, 133000000: clock frequency in Hz.
- BAUD_RATE, 12000000: line rate in bit/s; must satisfy BAUD_RATE <= CLOCK_FREQ/2.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries, power of two >= 2.

- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_BITS  word to transmit.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  FIFO can accept; registered, equals !full.
- cts_n  in  1  host clear-to-send (from ft232_rts_n), active-low, asynchronous.
- txd  out  1  serial output, idle high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
- busy  out  1  a frame is on the line (state != IDLE).

## Operation
- A push occurs on a rising edge with data_valid && data_ready. There is no push when full, even if a pop happens in the same cycle.
- cts_n passes through a 2-flop synchroniser; cts_sync is the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty and cts_sync == 0. The FIFO head is popped into the shift register in the same cycle.
  - START -> DATA after 1 bit period.
  - DATA -> PARITY after DATA_BITS bit periods, or -> STOP if PARITY == 0.
  - PARITY -> STOP after 1 bit period.
  - STOP -> START directly after STOP_BITS periods if the start condition holds; otherwise -> IDLE.
- Line levels per state: START drives txd=0. DATA drives shift[0], LSB first. STOP and IDLE drive txd=1.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: inverse of that XOR.
- CTS is examined only at frame boundaries. Deasserting it mid-frame never truncates a frame.
- Baud generator:
  - Accumulator width is $clog2(CLOCK_FREQ+BAUD_RATE).
  - It is cleared to 0 on the cycle a frame starts.
  - Each cycle, acc += BAUD_RATE. When the sum is >= CLOCK_FREQ, subtract CLOCK_FREQ and assert bit_tick.
  - The k-th bit of a frame ends ceil(k*CLOCK_FREQ/BAUD_RATE) cycles after the frame start. There is no cumulative drift.
- Reset values: txd=1, data_ready=0, fifo_level=0, busy=0. The FSM goes to IDLE, the FIFO is flushed and the accumulator is cleared.
- data_ready rises on the first clock after reset deasserts.

## Timing
- Push at edge t into an empty FIFO with the line idle and cts_sync==0:
  - fifo_level=1 after t.
  - txd falls after edge t+2.
- A cts_n change is visible to the FSM 2 cycles later.
- Back-to-back frames have zero idle cycles between the last stop-bit cycle and the next start bit.
- fifo_level updates one cycle after a push/pop. A simultaneous push and pop leaves the level unchanged.
- Reset asserted mid-frame forces txd=1 immediately (asynchronously). The partial frame is abandoned.

## Structure
- Shared package rs232_pkg holds:
  - PARITY_NONE/ODD/EVEN constants.
  - The FSM state encoding.
  - A frame_bits(DATA_BITS, PARITY, STOP_BITS) function.
- Sub-module rs232_baud_tick holds the fractional accumulator. Inputs: clock, reset, clear. Output: tick. It is reusable by the future receiver.
- The FIFO is inline: a register array with wrap-around pointers plus one extra bit to distinguish full from empty.

## Test plan
- Default parameters (133 MHz/12 Mbaud, 8N1), push 0x55:
  - txd sequence is 0,1,0,1,0,1,0,1,0,1.
  - Bit boundaries fall at 12, 23, 34 cycles from the start.
  - The frame lasts 111 cycles; busy is high for exactly 111 cycles.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, CLOCK_FREQ=16, BAUD_RATE=1, push 0x41:
  - txd is 0, 1000001, parity 0, 1, 1.
  - Each bit lasts 16 cycles; the frame is 176 cycles.
- cts_n=1, push 17 words 0x00..0x10:
  - data_ready drops after the 16th accept; fifo_level=16; txd stays 1.
  - After releasing cts_n, bytes 0x00..0x0F go out back-to-back with no idle cycles.
- Raise cts_n midway through frame 2 of 4 queued:
  - Frame 2 completes.
  - txd stays 1 until cts_n is low again, plus 2 cycles, then frames 3 and 4 follow.
- Assert reset during a DATA bit:
  - txd=1 and fifo_level=0 at once.
  - After release, a pushed 0xA5 transmits as a clean, correct frame.
- Push and pop on the same cycle with the FIFO at level 3: the level stays 3 and data order is preserved.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared constants, transmitter state encoding and frame helpers for the RS-232 blocks.
package rs232_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Line bits per frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic parity_of(input int mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Fractional baud generator: bit k ends ceil(k*CLOCK_FREQ/BAUD_RATE) cycles after clear,
// with no cumulative drift. Shared between transmitter and receiver.
module rs232_baud_tick #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int ACC_W = $clog2(CLOCK_FREQ + BAUD_RATE);
  localparam logic [ACC_W-1:0] INC  = ACC_W'(BAUD_RATE);
  localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLOCK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // Sum never overflows: acc < CLOCK_FREQ, so acc + BAUD_RATE < 2**ACC_W.
  always_comb begin
    sum  = acc + INC;
    tick = (sum >= WRAP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      acc <= '0;
    else if (clear) acc <= '0;
    else if (tick)  acc <= sum - WRAP;
    else            acc <= sum;
  end

endmodule

// File: rtl/rs232_tx_fifo.sv
// RS-232 transmitter with byte FIFO and CTS-gated frame starts; txd is registered and
// forced idle-high by reset.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | line high, waiting for data and cts_sync == 0
//   ST_START  | start bit (low)
//   ST_DATA   | DATA_BITS data bits, LSB first
//   ST_PARITY | parity bit (skipped when PARITY == PARITY_NONE)
//   ST_STOP   | STOP_BITS stop bits; may chain straight into ST_START
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          cts_n,
  output logic                          txd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, wr_next, rd_next;
  logic                 push, pop, empty, start_ok;
  logic [DATA_BITS-1:0] head;

  logic                 cts_meta, cts_sync;
  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [2:0]           bit_cnt;
  logic                 tick;
  logic                 line;

  assign push       = data_valid && data_ready;
  assign empty      = (wr_ptr == rd_ptr);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign wr_next    = wr_ptr + {{AW{1'b0}}, push};
  assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};
  assign fifo_level = wr_ptr - rd_ptr;
  assign start_ok   = !empty && !cts_sync;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_ready <= 1'b0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      data_ready <= ((wr_next - rd_next) != DEPTH_L);
    end
  end

  // Synchroniser resets to "not clear" so nothing starts before cts_n is really seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  rs232_baud_tick #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (pop),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    line       = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_START;
          pop        = 1'b1;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        line = shift[0];
        if (tick && bit_cnt == 3'd0)
          state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        line = par_bit;
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick && bit_cnt == 3'd0) begin
          if (start_ok) begin
            state_next = ST_START;
            pop        = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // bit_cnt is a down-counter reloaded on entry to DATA and STOP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= 3'd0;
      txd     <= 1'b1;
    end else begin
      txd <= line;
      if (pop) begin
        shift   <= head;
        par_bit <= parity_of(PARITY, ^head);
      end else if (state == ST_DATA && tick) begin
        shift <= shift >> 1;
      end
      if (state_next != state) begin
        if (state_next == ST_DATA)      bit_cnt <= DATA_LAST;
        else if (state_next == ST_STOP) bit_cnt <= STOP_LAST;
      end else if (tick && bit_cnt != 3'd0) begin
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Scoreboard bench: stimulus queues expected line frames, a monitor decodes txd against
// the ideal ceil(k*CLOCK_FREQ/BAUD_RATE) bit grid.
module tb_rs232_tx_fifo;
  import rs232_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_a, valid_b, ready_a, ready_b;
  logic       txd_a, txd_b, busy_a, busy_b;
  logic [4:0] level_a, level_b;
  logic       cts_n;
  logic       sel_b;
  logic       txd_m;

  always #5 clock = ~clock;

  rs232_tx_fifo dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(valid_a),
    .data_ready(ready_a), .cts_n(cts_n), .txd(txd_a), .fifo_level(level_a), .busy(busy_a)
  );

  rs232_tx_fifo #(
    .CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(PARITY_EVEN),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in[6:0]), .data_valid(valid_b),
    .data_ready(ready_b), .cts_n(cts_n), .txd(txd_b), .fifo_level(level_b), .busy(busy_b)
  );

  assign txd_m = sel_b ? txd_b : txd_a;

  typedef struct {
    logic [15:0] bits;   // line bits in transmit order, bit 0 = start bit
    int          nb;
    bit          b2b;    // must start on the cycle the previous frame ends
    logic [7:0]  d;
  } frame_t;

  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mon_frames = 0;
  int mon_start = 0;
  int mon_end = -1;
  int last_push = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int bnd(input int k, input bit b);
    longint cf, br;
    cf = b ? 64'd16 : 64'd133000000;
    br = b ? 64'd1  : 64'd12000000;
    return int'((longint'(k) * cf + br - 1) / br);
  endfunction

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin : monitor
    frame_t f;
    int start, k, bad_k, bad_off;
    bit bad, aborted;
    logic bad_val;
    forever begin
      @(negedge clock);
      if (reset !== 1'b0 || txd_m !== 1'b0) continue;
      start = cyc;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", start);
        for (int i = 0; i < 5000 && txd_m !== 1'b1; i++) @(negedge clock);
        continue;
      end
      f = exp_q.pop_front();
      mon_start = start;
      if (f.b2b) begin
        vectors++;
        if (start != mon_end) begin
          miscompares++;
          $display("FAIL frame_gap byte %02h: start cycle %0d, required %0d", f.d, start, mon_end);
        end
      end
      bad = 0; aborted = 0; k = 0; bad_k = 0; bad_off = 0; bad_val = 1'b0;
      for (int off = 0; off < bnd(f.nb, sel_b); off++) begin
        if (off > 0) @(negedge clock);
        if (reset !== 1'b0) begin aborted = 1; break; end
        while (off >= bnd(k + 1, sel_b)) k++;
        if (!bad && txd_m !== f.bits[k]) begin
          bad = 1; bad_k = k; bad_off = off; bad_val = txd_m;
        end
      end
      if (aborted) continue;
      mon_end = start + bnd(f.nb, sel_b);
      mon_frames++;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL frame byte %02h: line bit %0d at offset %0d is %b, required %b",
                 f.d, bad_k, bad_off, bad_val, f.bits[bad_k]);
      end
    end
  end

  task automatic push_word(input bit b, input logic [7:0] d, input logic [15:0] bits,
                           input int nb, input bit b2b);
    int t;
    t = 0;
    while (((b ? ready_b : ready_a) !== 1'b1) && t < 3000) begin @(negedge clock); t++; end
    if (t >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout byte %02h: data_ready is 0, required 1", d);
      return;
    end
    data_in = d;
    if (b) valid_b = 1'b1; else valid_a = 1'b1;
    exp_q.push_back('{bits, nb, b2b, d});
    @(negedge clock);
    valid_a = 1'b0; valid_b = 1'b0;
    last_push = cyc;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t, quiet;
    t = 0; quiet = 0;
    while (quiet < 4 && t < limit) begin
      @(negedge clock); t++;
      if (exp_q.size() == 0 && busy_a === 1'b0 && busy_b === 1'b0 && txd_m === 1'b1) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      vectors++; miscompares++;
      $display("FAIL %s: line busy after %0d cycles with %0d frames pending, required idle", name, t, exp_q.size());
    end
  endtask

  task automatic wait_frames(input string name, input int target, input int limit);
    int t;
    t = 0;
    while (mon_frames < target && t < limit) begin @(negedge clock); t++; end
    if (mon_frames < target) begin
      vectors++; miscompares++;
      $display("FAIL %s: %0d frames seen, required %0d", name, mon_frames, target);
    end
  endtask

  initial begin : stimulus
    int p, fall, busy_cnt, base, zeros, rel, old_start, t;
    int tr[3];
    logic prev;

    reset = 1'b1; cts_n = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_in = 8'h00; sel_b = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_txd_a", txd_a, 1);     chk("reset_ready_a", ready_a, 0);
    chk("reset_level_a", level_a, 0); chk("reset_busy_a", busy_a, 0);
    chk("reset_txd_b", txd_b, 1);     chk("reset_ready_b", ready_b, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset_a", ready_a, 1);
    chk("ready_after_reset_b", ready_b, 1);

    // 8N1 at 133 MHz / 12 Mbaud, 0x55
    cts_n = 1'b0;
    repeat (4) @(negedge clock);
    push_word(0, 8'h55, 16'h02AA, 10, 0);
    p = last_push;
    chk("level_after_push", level_a, 1);
    busy_cnt = 0; fall = -1; tr = '{-1, -1, -1}; t = 0; prev = txd_a;
    for (int i = 0; i < 140; i++) begin
      if (busy_a === 1'b1) busy_cnt++;
      if (txd_a !== prev) begin
        if (fall < 0) fall = cyc;
        else if (t < 3) begin tr[t] = cyc - fall; t++; end
      end
      prev = txd_a;
      @(negedge clock);
    end
    chk("txd_fall_latency", fall - p, 2);
    chk("bit_boundary_1", tr[0], 12);
    chk("bit_boundary_2", tr[1], 23);
    chk("bit_boundary_3", tr[2], 34);
    chk("busy_cycles_8n1", busy_cnt, 111);
    wait_idle("idle_after_0x55", 300);

    // 7E2 at 16 cycles per bit, 0x41
    sel_b = 1'b1;
    push_word(1, 8'h41, 16'h0682, 11, 0);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_b === 1'b1) busy_cnt++;
      @(negedge clock);
    end
    chk("busy_cycles_7e2", busy_cnt, 176);
    wait_idle("idle_after_0x41", 300);
    sel_b = 1'b0;

    // Fill the FIFO with CTS held off, then drain back-to-back
    cts_n = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 16; i++) push_word(0, 8'(i), f8n1(8'(i)), 10, i != 0);
    chk("ready_when_full", ready_a, 0);
    chk("level_when_full", level_a, 16);
    data_in = 8'h10; valid_a = 1'b1;
    exp_q.push_back('{f8n1(8'h10), 10, 1'b1, 8'h10});
    zeros = 0;
    repeat (5) begin @(negedge clock); if (txd_a !== 1'b1) zeros++; end
    chk("level_full_held", level_a, 16);
    chk("txd_low_while_cts_off", zeros, 0);
    cts_n = 1'b0;
    t = 0;
    while (ready_a !== 1'b1 && t < 500) begin @(negedge clock); t++; end
    chk("ready_after_drain_start", ready_a, 1);
    @(negedge clock);
    valid_a = 1'b0;
    wait_idle("drain_17", 4000);

    // CTS raised in the middle of frame 2 of 4
    cts_n = 1'b1;
    repeat (3) @(negedge clock);
    base = mon_frames;
    push_word(0, 8'h3C, f8n1(8'h3C), 10, 0);
    push_word(0, 8'hC3, f8n1(8'hC3), 10, 1);
    push_word(0, 8'h81, f8n1(8'h81), 10, 0);
    push_word(0, 8'h7E, f8n1(8'h7E), 10, 1);
    cts_n = 1'b0;
    wait_frames("cts_frame1", base + 1, 500);
    repeat (50) @(negedge clock);
    cts_n = 1'b1;
    wait_frames("cts_frame2", base + 2, 500);
    zeros = 0;
    repeat (300) begin @(negedge clock); if (txd_a !== 1'b1) zeros++; end
    chk("txd_held_by_cts", zeros, 0);
    chk("level_held_by_cts", level_a, 2);
    old_start = mon_start;
    cts_n = 1'b0;
    rel = cyc;
    t = 0;
    while (mon_start == old_start && t < 100) begin @(negedge clock); t++; end
    chk("cts_release_latency", mon_start - rel, 4);
    wait_idle("cts_frames_3_4", 600);

    // Reset during a data bit of 0x00
    cts_n = 1'b1;
    repeat (3) @(negedge clock);
    push_word(0, 8'h00, f8n1(8'h00), 10, 0);
    push_word(0, 8'h12, f8n1(8'h12), 10, 1);
    push_word(0, 8'h34, f8n1(8'h34), 10, 1);
    cts_n = 1'b0;
    t = 0;
    while (busy_a !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    repeat (40) @(negedge clock);
    chk("txd_in_data_bit", txd_a, 0);
    reset = 1'b1;
    #1;
    chk("txd_on_reset", txd_a, 1);
    chk("level_on_reset", level_a, 0);
    chk("busy_on_reset", busy_a, 0);
    repeat (3) @(negedge clock);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_midframe_reset", ready_a, 1);
    repeat (3) @(negedge clock);
    push_word(0, 8'hA5, 16'h034A, 10, 0);
    wait_idle("frame_0xa5", 300);

    // Push and pop on the same edge at level 3
    cts_n = 1'b1;
    repeat (3) @(negedge clock);
    push_word(0, 8'h11, f8n1(8'h11), 10, 0);
    push_word(0, 8'h22, f8n1(8'h22), 10, 1);
    push_word(0, 8'h33, f8n1(8'h33), 10, 1);
    chk("level_before_pushpop", level_a, 3);
    cts_n = 1'b0;
    repeat (2) @(negedge clock);
    data_in = 8'h44; valid_a = 1'b1;
    exp_q.push_back('{f8n1(8'h44), 10, 1'b1, 8'h44});
    @(negedge clock);
    valid_a = 1'b0;
    chk("level_at_pushpop", level_a, 3);
    chk("busy_at_pushpop", busy_a, 1);
    @(negedge clock);
    chk("level_after_pushpop", level_a, 3);
    wait_idle("pushpop_drain", 800);

    chk("frames_seen", mon_frames, 28);
    chk("expected_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #400000;
    miscompares++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
